// File: rtl/decode_stage.sv
// Registered RV32I decode stage: opcode decode, illegal flagging, load-use bubble and flush.
// Latency 1 cycle accept-to-out_valid; holds outputs while out_valid & !out_ready, stalls fetch on load-use.
module decode_stage #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit HAZARD_CHECK   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instr,
    input  logic [XLEN-1:0]           pc,
    input  logic                      flush,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [XLEN-1:0]           out_pc,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic [REG_ADDR_WIDTH-1:0] out_rs1,
    output logic [REG_ADDR_WIDTH-1:0] out_rs2,
    output logic [2:0]                out_funct3,
    output logic                      out_branch,
    output logic                      out_jump,
    output logic                      out_reg_write,
    output logic                      out_mem_read,
    output logic                      out_mem_to_reg,
    output logic                      out_mem_write,
    output logic                      out_alu_src,
    output logic                      out_is_imm,
    output logic                      out_illegal,
    output logic [1:0]                out_alu_op,
    output logic                      hazard_stall
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [REG_ADDR_WIDTH-1:0] dec_rd, dec_rs1, dec_rs2;
    logic dec_branch, dec_jump, dec_reg_write, dec_mem_read, dec_mem_to_reg;
    logic dec_mem_write, dec_alu_src, dec_is_imm, dec_illegal;
    logic [1:0] dec_alu_op;
    logic uses_rs1, uses_rs2;
    logic unused_funct7;

    assign dec_rd  = REG_ADDR_WIDTH'(instr[11:7]);
    assign dec_rs1 = REG_ADDR_WIDTH'(instr[19:15]);
    assign dec_rs2 = REG_ADDR_WIDTH'(instr[24:20]);
    assign unused_funct7 = ^instr[31:25];

    always_comb begin
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_is_imm     = 1'b0;
        dec_illegal    = 1'b0;
        dec_alu_op     = 2'b00;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        case (instr[6:0])
            OP_R: begin
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b10;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_IMM: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_is_imm    = 1'b1;
                dec_alu_op    = 2'b10;
                uses_rs1      = 1'b1;
            end
            OP_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
                dec_is_imm     = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec_branch = 1'b1;
                dec_alu_op = 2'b01;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_JALR: begin
                dec_branch    = 1'b1;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_is_imm    = 1'b1;
                dec_alu_op    = 2'b11;
                uses_rs1      = 1'b1;
            end
            OP_JAL: begin
                dec_branch    = 1'b1;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b11;
            end
            OP_LUI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_is_imm    = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        // writes to x0 are architecturally discarded
        if (dec_rd == '0) dec_reg_write = 1'b0;
    end

    generate
        if (HAZARD_CHECK) begin : g_hazard
            assign hazard_stall = in_valid & out_valid & out_mem_read & (out_rd != '0) &
                                  ((uses_rs1 & (dec_rs1 == out_rd)) |
                                   (uses_rs2 & (dec_rs2 == out_rd)));
        end else begin : g_no_hazard
            assign hazard_stall = 1'b0;
        end
    endgenerate

    assign in_ready = (!out_valid | out_ready) & !hazard_stall & !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_funct3     <= '0;
            out_branch     <= 1'b0;
            out_jump       <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_mem_write  <= 1'b0;
            out_alu_src    <= 1'b0;
            out_is_imm     <= 1'b0;
            out_illegal    <= 1'b0;
            out_alu_op     <= 2'b00;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid      <= 1'b1;
            out_pc         <= pc;
            out_rd         <= dec_rd;
            out_rs1        <= dec_rs1;
            out_rs2        <= dec_rs2;
            out_funct3     <= instr[14:12];
            out_branch     <= dec_branch;
            out_jump       <= dec_jump;
            out_reg_write  <= dec_reg_write;
            out_mem_read   <= dec_mem_read;
            out_mem_to_reg <= dec_mem_to_reg;
            out_mem_write  <= dec_mem_write;
            out_alu_src    <= dec_alu_src;
            out_is_imm     <= dec_is_imm;
            out_illegal    <= dec_illegal;
            out_alu_op     <= dec_alu_op;
        end else if (out_ready) begin
            // covers both the load-use bubble and a plain drain
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan checks plus randomized traffic against a spec-level model.
module tb_decode_stage;

    logic        clk, rst, in_valid, flush, out_ready;
    logic [31:0] instr, pc;

    logic a_in_ready, a_out_valid, a_haz, b_in_ready, b_out_valid, b_haz;
    logic [31:0] a_pc, b_pc;
    logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
    logic [2:0]  a_f3, b_f3;
    logic a_br, a_jp, a_rw, a_mr, a_m2r, a_mw, a_as, a_imm, a_ill;
    logic b_br, b_jp, b_rw, b_mr, b_m2r, b_mw, b_as, b_imm, b_ill;
    logic [1:0]  a_op, b_op;

    decode_stage #(.XLEN(32), .REG_ADDR_WIDTH(5), .HAZARD_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .instr(instr), .pc(pc),
        .flush(flush), .out_ready(out_ready), .out_valid(a_out_valid), .out_pc(a_pc),
        .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_funct3(a_f3),
        .out_branch(a_br), .out_jump(a_jp), .out_reg_write(a_rw), .out_mem_read(a_mr),
        .out_mem_to_reg(a_m2r), .out_mem_write(a_mw), .out_alu_src(a_as), .out_is_imm(a_imm),
        .out_illegal(a_ill), .out_alu_op(a_op), .hazard_stall(a_haz));

    decode_stage #(.XLEN(32), .REG_ADDR_WIDTH(5), .HAZARD_CHECK(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr), .pc(pc),
        .flush(flush), .out_ready(out_ready), .out_valid(b_out_valid), .out_pc(b_pc),
        .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct3(b_f3),
        .out_branch(b_br), .out_jump(b_jp), .out_reg_write(b_rw), .out_mem_read(b_mr),
        .out_mem_to_reg(b_m2r), .out_mem_write(b_mw), .out_alu_src(b_as), .out_is_imm(b_imm),
        .out_illegal(b_ill), .out_alu_op(b_op), .hazard_stall(b_haz));

    logic [60:0] d_fields [2];
    logic        d_vld [2], d_haz [2], d_rdy [2];
    logic [10:0] a_ctrl;
    assign d_fields[0] = {a_pc, a_rd, a_rs1, a_rs2, a_f3, a_br, a_jp, a_rw, a_mr, a_m2r, a_mw, a_as, a_imm, a_ill, a_op};
    assign d_fields[1] = {b_pc, b_rd, b_rs1, b_rs2, b_f3, b_br, b_jp, b_rw, b_mr, b_m2r, b_mw, b_as, b_imm, b_ill, b_op};
    assign a_ctrl = d_fields[0][10:0];
    assign d_vld[0] = a_out_valid;  assign d_vld[1] = b_out_valid;
    assign d_haz[0] = a_haz;        assign d_haz[1] = b_haz;
    assign d_rdy[0] = a_in_ready;   assign d_rdy[1] = b_in_ready;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic branch, jump, reg_write, mem_read, mem_to_reg, mem_write, alu_src, is_imm, illegal;
        logic [1:0] alu_op;
        logic u1, u2;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] i);
        dec_t d = '0;
        case (i[6:0])
            7'b0110011: begin d.reg_write = 1; d.alu_op = 2; d.u1 = 1; d.u2 = 1; end
            7'b0010011: begin d.reg_write = 1; d.alu_src = 1; d.is_imm = 1; d.alu_op = 2; d.u1 = 1; end
            7'b0000011: begin d.reg_write = 1; d.mem_read = 1; d.mem_to_reg = 1; d.alu_src = 1; d.is_imm = 1; d.u1 = 1; end
            7'b0100011: begin d.mem_write = 1; d.alu_src = 1; d.u1 = 1; d.u2 = 1; end
            7'b1100011: begin d.branch = 1; d.alu_op = 1; d.u1 = 1; d.u2 = 1; end
            7'b1100111: begin d.branch = 1; d.jump = 1; d.reg_write = 1; d.alu_src = 1; d.is_imm = 1; d.alu_op = 3; d.u1 = 1; end
            7'b1101111: begin d.branch = 1; d.jump = 1; d.reg_write = 1; d.alu_op = 3; end
            7'b0110111: begin d.reg_write = 1; d.alu_src = 1; d.is_imm = 1; end
            default:    d.illegal = 1;
        endcase
        if (i[11:7] == 0) d.reg_write = 0;
        return d;
    endfunction

    function automatic logic [60:0] exp_fields(input logic [31:0] i, input logic [31:0] p);
        dec_t d = decode(i);
        return {p, i[11:7], i[19:15], i[24:20], i[14:12], d.branch, d.jump, d.reg_write, d.mem_read,
                d.mem_to_reg, d.mem_write, d.alu_src, d.is_imm, d.illegal, d.alu_op};
    endfunction

    logic        m_vld [2] = '{1'b0, 1'b0};
    logic [31:0] m_instr [2] = '{32'h0, 32'h0};
    logic [31:0] m_pc [2] = '{32'h0, 32'h0};

    // A held load whose destination the incoming instruction reads forces a bubble.
    function automatic logic exp_haz(input int k);
        dec_t held = decode(m_instr[k]);
        dec_t inc  = decode(instr);
        logic [4:0] rd = m_instr[k][11:7];
        if (k != 0 || !in_valid || !m_vld[k] || !held.mem_read || rd == 0) return 1'b0;
        return (inc.u1 && instr[19:15] == rd) || (inc.u2 && instr[24:20] == rd);
    endfunction

    function automatic logic exp_rdy(input int k);
        return (!m_vld[k] || out_ready) && !exp_haz(k) && !flush;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_vld[k] <= 1'b0;
            end else if (flush) begin
                m_vld[k] <= 1'b0;
            end else if (in_valid && exp_rdy(k)) begin
                m_vld[k]   <= 1'b1;
                m_instr[k] <= instr;
                m_pc[k]    <= pc;
            end else if (out_ready) begin
                m_vld[k] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model.valid[%0d]", k), 64'(d_vld[k]), 64'(m_vld[k]));
            chk($sformatf("model.hazard[%0d]", k), 64'(d_haz[k]), 64'(exp_haz(k)));
            chk($sformatf("model.in_ready[%0d]", k), 64'(d_rdy[k]), 64'(exp_rdy(k)));
            if (m_vld[k])
                chk($sformatf("model.fields[%0d]", k), 64'(d_fields[k]), 64'(exp_fields(m_instr[k], m_pc[k])));
        end
    end

    // ---------------- stimulus ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p, input logic f, input logic r);
        in_valid = v; instr = i; pc = p; flush = f; out_ready = r;
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] I_USE  = 32'h00528333;
    localparam logic [31:0] I_ADD0 = 32'h00208033;

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h7F};

    initial begin
        logic hold;
        rst = 1'b1;
        drive(0, 0, 0, 0, 1);
        tick();
        #1;
        chk("reset.valid", 64'(a_out_valid), 0);
        chk("reset.fields", 64'(d_fields[0]), 0);
        rst = 1'b0;
        tick();

        // decode table streamed back to back
        drive(1, I_ADD, 32'h100, 0, 1); tick();
        drive(1, I_LW, 32'h104, 0, 1); #1;
        chk("add.ctrl", 64'(a_ctrl), 64'h102);
        chk("add.rd", 64'(a_rd), 3);
        chk("add.pc", 64'(a_pc), 32'h100);
        tick();
        drive(1, I_SW, 32'h108, 0, 1); #1;
        chk("lw.ctrl", 64'(a_ctrl), 64'h1D8);
        chk("lw.rd", 64'(a_rd), 5);
        tick();
        drive(1, I_BAD, 32'h10C, 0, 1); #1;
        chk("sw.ctrl", 64'(a_ctrl), 64'h030);
        chk("sw.rs2", 64'(a_rs2), 2);
        tick();
        drive(0, 0, 0, 0, 1); #1;
        chk("bad.ctrl", 64'(a_ctrl), 64'h004);
        chk("bad.valid", 64'(a_out_valid), 1);
        tick();

        // load-use pair
        drive(1, I_LW, 32'h200, 0, 1); tick();
        drive(1, I_USE, 32'h204, 0, 1); #1;
        chk("lu.hazard", 64'(a_haz), 1);
        chk("lu.in_ready", 64'(a_in_ready), 0);
        chk("lu.nh_hazard", 64'(b_haz), 0);
        chk("lu.nh_in_ready", 64'(b_in_ready), 1);
        tick(); #1;
        chk("lu.bubble", 64'(a_out_valid), 0);
        chk("lu.after_in_ready", 64'(a_in_ready), 1);
        chk("lu.nh_rd", 64'(b_rd), 6);
        chk("lu.nh_valid", 64'(b_out_valid), 1);
        tick();
        drive(0, 0, 0, 0, 1); #1;
        chk("lu.use_valid", 64'(a_out_valid), 1);
        chk("lu.use_rd", 64'(a_rd), 6);
        tick();

        // backpressure for three cycles
        drive(1, I_ADD, 32'h300, 0, 1); tick();
        drive(1, I_LW, 32'h304, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp.in_ready", 64'(a_in_ready), 0);
            chk("bp.hold", 64'(d_fields[0]), 64'(exp_fields(I_ADD, 32'h300)));
            tick();
        end
        out_ready = 1'b1; #1;
        chk("bp.release", 64'(a_in_ready), 1);
        tick();
        drive(1, I_SW, 32'h308, 1, 0); #1;
        chk("bp.next_rd", 64'(a_rd), 5);
        chk("fl.in_ready", 64'(a_in_ready), 0);
        tick();
        drive(0, 0, 0, 0, 1); #1;
        chk("fl.valid", 64'(a_out_valid), 0);
        tick(); #1;
        chk("fl.dropped", 64'(a_out_valid), 0);

        // write to x0
        drive(1, I_ADD0, 32'h400, 0, 1); tick();
        drive(0, 0, 0, 0, 1); #1;
        chk("x0.valid", 64'(a_out_valid), 1);
        chk("x0.reg_write", 64'(a_rw), 0);
        chk("x0.illegal", 64'(a_ill), 0);
        tick();

        // asynchronous reset while a valid instruction is held
        drive(1, I_ADD, 32'h500, 0, 0); tick();
        in_valid = 1'b0; #1;
        chk("arst.pre_valid", 64'(a_out_valid), 1);
        rst = 1'b1; #1;
        chk("arst.valid", 64'(a_out_valid), 0);
        chk("arst.fields", 64'(d_fields[0]), 0);
        chk("arst.hazard", 64'(a_haz), 0);
        rst = 1'b0;
        drive(1, I_LW, 32'h600, 0, 1); tick();
        drive(0, 0, 0, 0, 1); #1;
        chk("arst.first_accept", 64'(a_out_valid), 1);
        chk("arst.first_rd", 64'(a_rd), 5);

        // randomized traffic; upstream holds an instruction it could not hand over
        hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!hold) begin
                instr = $urandom;
                instr[6:0]   = ops[$urandom_range(0, 8)];
                instr[11:7]  = 5'($urandom_range(0, 3));
                instr[19:15] = 5'($urandom_range(0, 3));
                instr[24:20] = 5'($urandom_range(0, 3));
                pc = $urandom;
                in_valid = ($urandom_range(0, 3) != 0);
            end
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            hold = in_valid && !a_in_ready && !flush;
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered decode stage for the Abejaruco RV32I core. It is the parametrised successor of the combinational control unit. It decodes a 32-bit instruction into control, register-index and funct3 fields, and holds them in a pipeline register with a valid/ready handshake toward fetch and execute. It adds three things the combinational unit lacks: JAL/JALR/LUI/OP-IMM decode, illegal-opcode flagging, and load-use hazard bubbling with flush.

Parameters:
XLEN, 32, width of pc / out_pc
REG_ADDR_WIDTH, 5, register index width
HAZARD_CHECK, 1, 1 = load-use bubble logic enabled; 0 = hazard_stall tied to 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  fetch presents instr/pc
in_ready  out  1  stage accepts instr this cycle
instr  in  32  instruction word
pc  in  XLEN  instruction address
flush  in  1  kill held and incoming instruction
out_ready  in  1  execute accepts output
out_valid  out  1  output register holds a valid decoded instruction
out_pc  out  XLEN  registered pc
out_rd, out_rs1, out_rs2  out  REG_ADDR_WIDTH each  instr[11:7], [19:15], [24:20]
out_funct3  out  3  instr[14:12]
out_branch, out_jump, out_reg_write, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_is_imm, out_illegal  out  1 each  control bits
out_alu_op  out  2  00 add/addr, 01 branch compare, 10 funct-decoded, 11 jump
hazard_stall  out  1  load-use bubble being inserted this cycle

Behaviour:
- Decode by opcode instr[6:0]. Listed bits are 1; every unlisted control bit is 0.
  - 0110011 R: reg_write; alu_op=10.
  - 0010011 OP-IMM: reg_write, alu_src, is_imm; alu_op=10.
  - 0000011 LOAD: reg_write, mem_read, mem_to_reg, alu_src, is_imm; alu_op=00.
  - 0100011 STORE: mem_write, alu_src; alu_op=00.
  - 1100011 BRANCH: branch; alu_op=01.
  - 1100111 JALR: branch, jump, reg_write, alu_src, is_imm; alu_op=11.
  - 1101111 JAL: branch, jump, reg_write; alu_op=11.
  - 0110111 LUI: reg_write, alu_src, is_imm; alu_op=00.
  - Any other opcode: illegal=1; all enables (reg_write, mem_read, mem_write, branch, jump) are 0.
- reg_write is forced to 0 when rd==0.
- Register uses:
  - uses_rs1 = R, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2 = R, STORE, BRANCH.
- Hazard (combinational): hazard_stall = HAZARD_CHECK & in_valid & out_valid & out_mem_read & out_rd!=0 & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
- in_ready = (!out_valid | out_ready) & !hazard_stall & !flush.
- Registered update on each rising edge, in priority order:
  1. flush=1: out_valid<=0. Incoming instr is discarded; other fields are don't-care.
  2. in_valid & in_ready: load all decoded fields; out_valid<=1.
  3. hazard_stall & out_ready: out_valid<=0 (bubble). Upstream holds instr, which is accepted the next cycle once the load has left.
  4. out_valid & out_ready (no new input): out_valid<=0.
  5. Otherwise: hold all outputs (backpressure). Outputs must stay stable while out_valid & !out_ready.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 instr/cycle with no hazard. A load-use pair costs exactly 1 bubble.
- Reset, asynchronous, takes effect immediately, including mid-transfer:
  - out_valid, all control bits, out_alu_op, out_rd/rs1/rs2, out_funct3, out_pc and out_illegal go to 0.
  - hazard_stall=0 follows because out_valid=0.
  - First accept is possible on the first edge after rst deasserts.
- flush together with hazard_stall: flush wins; the bubble is irrelevant.
- flush together with out_ready=0: output is still invalidated.
- An illegal instruction propagates normally with out_valid=1 and out_illegal=1. The stage does not trap.

Test Plan:
- Reset mid-run: assert rst while out_valid=1 -> out_valid=0 and every output=0 asynchronously, before the next edge.
- Decode table: stream 0x002081B3 (add x3,x1,x2), 0x0000A283 (lw x5,0(x1)), 0x0020A223 (sw x2,4(x1)), 0xFFFFFFFF with out_ready=1. Required outputs on consecutive cycles:
  - add: reg_write=1, alu_op=10, rd=3.
  - lw: reg_write=mem_read=mem_to_reg=alu_src=is_imm=1, alu_op=00, rd=5.
  - sw: mem_write=alu_src=1, reg_write=0, rs2=2.
  - 0xFFFFFFFF: illegal=1, all enables 0.
- Load-use: lw x5 then 0x00528333 (add x6,x5,x5) back-to-back -> hazard_stall=1 and in_ready=0 for one cycle; out_valid=0 for one cycle; add appears with rd=6 one cycle later. With HAZARD_CHECK=0, no bubble occurs.
- Backpressure: out_ready=0 for 3 cycles with add held -> in_ready=0 and outputs unchanged for 3 cycles; the next instr is accepted on the cycle out_ready=1.
- Flush: flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming instr never appears, in_ready=0 during flush.
- rd=x0: 0x00208033 (add x0,x1,x2) -> out_reg_write=0, out_illegal=0, out_valid=1.
